lowampa_trig_scaler: RTL

LOWAMPA_TRIG_SCALER -- requirements
Module: lowampa_trig_scaler

---
 rtl/lowampa_trig_pkg.sv | 16 +
 rtl/lowampa_scaler_chan.sv | 59 +++++
 rtl/lowampa_trig_scaler.sv | 96 +++++++++
 3 files changed

// File: rtl/lowampa_trig_pkg.sv
// Shared constants and channel ordering for the low-amplitude trigger scaler.
// Each upstream module contributes two beams with two thresholds each.
package lowampa_trig_pkg;

    localparam int NBEAM_PER_MOD = 2;
    localparam int NTHR          = 2;
    localparam int NTRIG_PER_MOD = NBEAM_PER_MOD * NTHR;

    typedef enum logic [1:0] {
        A_THR0 = 2'd0,
        A_THR1 = 2'd1,
        B_THR0 = 2'd2,
        B_THR1 = 2'd3
    } trig_chan_e;

endpackage

// File: rtl/lowampa_scaler_chan.sv
// One scaler channel: input register, rising-edge detect with mask,
// saturating gate counter and the hold register exposed for readout.
module lowampa_scaler_chan
    import lowampa_trig_pkg::*;
#(
    parameter int CBITS = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trig_i,
    input  logic             mask_i,
    input  logic             term_i,
    output logic [CBITS-1:0] hold_o
);

    logic             trig_q;
    logic             trig_qq;
    logic             armed_q;
    logic             inc_q;
    logic             edge_det;
    logic [CBITS-1:0] sum;
    logic [CBITS-1:0] count_d;
    logic [CBITS-1:0] count_q;
    logic [CBITS-1:0] hold_q;

    function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v, input logic inc);
        if (inc && (v != {CBITS{1'b1}}))
            return v + {{(CBITS-1){1'b0}}, 1'b1};
        return v;
    endfunction

    // armed_q needs a genuine low sample after reset, so a level held through release never counts
    assign edge_det = trig_q & ~trig_qq & armed_q & ~mask_i;
    assign sum      = sat_inc(count_q, inc_q);
    assign count_d  = term_i ? '0 : sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_q  <= 1'b0;
            trig_qq <= 1'b0;
            armed_q <= 1'b0;
            inc_q   <= 1'b0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            trig_q  <= trig_i;
            trig_qq <= trig_q;
            armed_q <= armed_q | ~trig_i;
            inc_q   <= edge_det;
            count_q <= count_d;
            // an increment arriving on the terminal cycle closes into this gate
            if (term_i)
                hold_q <= sum;
        end
    end

    assign hold_o = hold_q;

endmodule

// File: rtl/lowampa_trig_scaler.sv
// Gate timer, channel array and registered readout mux for the trigger
// rate scaler; counts are latched into hold registers at every gate end.
module lowampa_trig_scaler
    import lowampa_trig_pkg::*;
#(
    parameter int          NMOD   = 8,
    parameter int unsigned PERIOD = 37500000,
    parameter int          CBITS  = 16,
    localparam int         NCH    = NTRIG_PER_MOD * NMOD,
    localparam int         AW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   trig_i,
    input  logic [NCH-1:0]   mask_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             rd_en_i,
    output logic [CBITS-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             update_o,
    output logic [31:0]      period_cnt_o
);

    localparam logic [31:0] TERM = 32'(PERIOD - 1);

    logic             run_q;
    logic [31:0]      timer_d;
    logic [31:0]      timer_q;
    logic             term;
    logic             update_q;
    logic [31:0]      period_q;
    logic [CBITS-1:0] rd_data_q;
    logic             rd_valid_q;
    logic [CBITS-1:0] hold_ext [2**AW];

    assign term = (timer_q == TERM);

    // the timer holds at 0 for the first edge after reset, then advances
    always_comb begin
        timer_d = timer_q;
        if (term)
            timer_d = '0;
        else if (run_q)
            timer_d = timer_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            timer_q  <= '0;
            update_q <= 1'b0;
            period_q <= '0;
        end else begin
            run_q    <= 1'b1;
            timer_q  <= timer_d;
            update_q <= term;
            if (term)
                period_q <= period_q + 32'd1;
        end
    end

    for (genvar g = 0; g < 2**AW; g++) begin : g_chan
        if (g < NCH) begin : g_live
            lowampa_scaler_chan #(
                .CBITS(CBITS)
            ) u_chan (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .trig_i (trig_i[g]),
                .mask_i (mask_i[g]),
                .term_i (term),
                .hold_o (hold_ext[g])
            );
        end else begin : g_pad
            assign hold_ext[g] = '0;
        end
    end

    // addresses beyond the last channel land on the zero padding entries
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i)
                rd_data_q <= hold_ext[rd_addr_i];
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign update_o     = update_q;
    assign period_cnt_o = period_q;

endmodule
